// File: rtl/peripheral_msi_arbiter_wb.sv
// Wishbone N-master to 1-slave round-robin arbiter.
// Grant is held for the whole bus cycle; a watchdog errors out stalled transfers.
module peripheral_msi_arbiter_wb #(
    parameter int DW              = 32,
    parameter int AW              = 32,
    parameter int NUM_MASTERS     = 2,
    parameter int TIMEOUT         = 255,
    parameter int MASTER_SEL_BITS = $clog2(NUM_MASTERS)
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic [NUM_MASTERS-1:0][AW-1:0]  wbm_adr_i,
    input  logic [NUM_MASTERS-1:0][DW-1:0]  wbm_dat_i,
    input  logic [NUM_MASTERS-1:0][3:0]     wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]          wbm_we_i,
    input  logic [NUM_MASTERS-1:0]          wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]          wbm_stb_i,
    input  logic [NUM_MASTERS-1:0][2:0]     wbm_cti_i,
    input  logic [NUM_MASTERS-1:0][1:0]     wbm_bte_i,
    output logic [NUM_MASTERS-1:0][DW-1:0]  wbm_dat_o,
    output logic [NUM_MASTERS-1:0]          wbm_ack_o,
    output logic [NUM_MASTERS-1:0]          wbm_err_o,
    output logic [NUM_MASTERS-1:0]          wbm_rty_o,
    output logic [AW-1:0]                   wbs_adr_o,
    output logic [DW-1:0]                   wbs_dat_o,
    output logic [3:0]                      wbs_sel_o,
    output logic                            wbs_we_o,
    output logic                            wbs_cyc_o,
    output logic                            wbs_stb_o,
    output logic [2:0]                      wbs_cti_o,
    output logic [1:0]                      wbs_bte_o,
    input  logic [DW-1:0]                   wbs_dat_i,
    input  logic                            wbs_ack_i,
    input  logic                            wbs_err_i,
    input  logic                            wbs_rty_i
);

    localparam int WDT_BITS = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDT_BITS-1:0] WDT_MAX = WDT_BITS'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [MASTER_SEL_BITS-1:0] gnt;
    logic [MASTER_SEL_BITS-1:0] gnt_nxt;
    logic [MASTER_SEL_BITS-1:0] last;
    logic [MASTER_SEL_BITS-1:0] last_nxt;
    logic [MASTER_SEL_BITS-1:0] pick;
    logic [MASTER_SEL_BITS-1:0] idx;
    logic [WDT_BITS-1:0]        wdt;
    logic [WDT_BITS-1:0]        wdt_nxt;
    logic                       busy;
    logic                       any_req;
    logic                       rearb;
    logic                       grant_load;
    logic                       slv_term;
    logic                       wdt_err;

    assign busy       = (state == BUSY);
    assign any_req    = |wbm_cyc_i;
    assign rearb      = !busy || !wbm_cyc_i[gnt];
    assign grant_load = rearb && any_req;
    assign slv_term   = wbs_ack_i || wbs_err_i || wbs_rty_i;

    // Round-robin search: nearest requester after the last served master wins
    always_comb begin
        pick = last;
        idx  = last;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = MASTER_SEL_BITS'((int'(last) + i) % NUM_MASTERS);
            if (wbm_cyc_i[idx]) begin
                pick = idx;
            end
        end
    end

    // State, grant and watchdog registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= MASTER_SEL_BITS'(NUM_MASTERS - 1);
            wdt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            wdt   <= wdt_nxt;
        end
    end

    // Next state: re-arbitrate when idle or when the owner drops its cycle
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        if (rearb) begin
            if (any_req) begin
                state_nxt = BUSY;
                gnt_nxt   = pick;
                last_nxt  = pick;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // Watchdog counts stalled strobes; any termination, grant change or expiry clears it
    always_comb begin
        wdt_nxt = '0;
        if (!grant_load && wbs_cyc_o && wbs_stb_o && !slv_term &&
            wdt != WDT_MAX) begin
            wdt_nxt = wdt + WDT_BITS'(1);
        end
    end

    // Outputs: slave side muxed from the grant, responses steered to the owner
    always_comb begin
        wbs_cyc_o = busy && wbm_cyc_i[gnt];
        wbs_stb_o = busy && wbm_stb_i[gnt];
        wbs_we_o  = busy && wbm_we_i[gnt];
        wbs_adr_o = wbm_adr_i[gnt];
        wbs_dat_o = wbm_dat_i[gnt];
        wbs_sel_o = wbm_sel_i[gnt];
        wbs_cti_o = wbm_cti_i[gnt];
        wbs_bte_o = wbm_bte_i[gnt];
        wdt_err   = (TIMEOUT != 0) && (wdt == WDT_MAX) &&
                    wbs_cyc_o && wbs_stb_o && !slv_term;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            wbm_dat_o[i] = wbs_dat_i;
            wbm_ack_o[i] = busy && (gnt == MASTER_SEL_BITS'(i)) && wbs_ack_i;
            wbm_rty_o[i] = busy && (gnt == MASTER_SEL_BITS'(i)) && wbs_rty_i;
            wbm_err_o[i] = busy && (gnt == MASTER_SEL_BITS'(i)) &&
                           (wbs_err_i || wdt_err);
        end
    end

endmodule

// File: tb/tb_peripheral_msi_arbiter_wb.sv
// Bench for the Wishbone 2-master arbiter with a 4-cycle watchdog.
// Directed vectors plus a cycle-level ownership model checked every cycle.
module tb_peripheral_msi_arbiter_wb;

    localparam int TOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][31:0] m_adr;
    logic [1:0][31:0] m_dat;
    logic [1:0][3:0]  m_sel;
    logic [1:0]       m_we;
    logic [1:0]       m_cyc;
    logic [1:0]       m_stb;
    logic [1:0][2:0]  m_cti;
    logic [1:0][1:0]  m_bte;
    logic [1:0][31:0] m_rdat;
    logic [1:0]       m_ack;
    logic [1:0]       m_err;
    logic [1:0]       m_rty;
    logic [31:0]      s_adr;
    logic [31:0]      s_wdat;
    logic [3:0]       s_sel;
    logic             s_we;
    logic             s_cyc;
    logic             s_stb;
    logic [2:0]       s_cti;
    logic [1:0]       s_bte;
    logic [31:0]      s_rdat;
    logic             s_ack;
    logic             s_err;
    logic             s_rty;

    int n_chk  = 0;
    int n_pass = 0;

    peripheral_msi_arbiter_wb #(
        .DW(32),
        .AW(32),
        .NUM_MASTERS(2),
        .TIMEOUT(TOUT)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbm_adr_i(m_adr),
        .wbm_dat_i(m_dat),
        .wbm_sel_i(m_sel),
        .wbm_we_i (m_we),
        .wbm_cyc_i(m_cyc),
        .wbm_stb_i(m_stb),
        .wbm_cti_i(m_cti),
        .wbm_bte_i(m_bte),
        .wbm_dat_o(m_rdat),
        .wbm_ack_o(m_ack),
        .wbm_err_o(m_err),
        .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr),
        .wbs_dat_o(s_wdat),
        .wbs_sel_o(s_sel),
        .wbs_we_o (s_we),
        .wbs_cyc_o(s_cyc),
        .wbs_stb_o(s_stb),
        .wbs_cti_o(s_cti),
        .wbs_bte_o(s_bte),
        .wbs_dat_i(s_rdat),
        .wbs_ack_i(s_ack),
        .wbs_err_i(s_err),
        .wbs_rty_i(s_rty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the bus, who was served last, and how long the owner has stalled
    logic       m_bsy;
    logic       m_own;
    logic       m_ptr;
    int         m_run;
    logic [1:0] pk;
    logic       e_cyc;
    logic       e_stb;
    logic       e_we;
    logic       wd;
    logic       stalled;
    logic [1:0] e_ack;
    logic [1:0] e_err;
    logic [1:0] e_rty;

    // Next master after ptr gets priority; ptr itself comes last
    function automatic logic [1:0] rr_pick(input logic ptr, input logic [1:0] req);
        if (req[~ptr]) return {1'b1, ~ptr};
        if (req[ptr]) return {1'b1, ptr};
        return 2'b00;
    endfunction

    assign pk      = rr_pick(m_ptr, m_cyc);
    assign stalled = e_cyc && e_stb && !(s_ack || s_err || s_rty);

    always_comb begin
        e_cyc = m_bsy && m_cyc[m_own];
        e_stb = m_bsy && m_stb[m_own];
        e_we  = m_bsy && m_we[m_own];
        wd    = ((m_run % (TOUT + 1)) == TOUT) && e_cyc && e_stb &&
                !(s_ack || s_err || s_rty);
        e_ack = 2'b00;
        e_err = 2'b00;
        e_rty = 2'b00;
        if (m_bsy) begin
            e_ack[m_own] = s_ack;
            e_rty[m_own] = s_rty;
            e_err[m_own] = s_err || wd;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bsy <= 1'b0;
            m_own <= 1'b0;
            m_ptr <= 1'b1;
            m_run <= 0;
        end else begin
            if (!m_bsy || !m_cyc[m_own]) begin
                m_bsy <= pk[1];
                if (pk[1]) begin
                    m_own <= pk[0];
                    m_ptr <= pk[0];
                end
            end
            m_run <= stalled ? m_run + 1 : 0;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("wbs_cyc", 64'(s_cyc), 64'(e_cyc));
        chk("wbs_stb", 64'(s_stb), 64'(e_stb));
        chk("wbs_we", 64'(s_we), 64'(e_we));
        chk("wbm_ack", 64'(m_ack), 64'(e_ack));
        chk("wbm_err", 64'(m_err), 64'(e_err));
        chk("wbm_rty", 64'(m_rty), 64'(e_rty));
        chk("wbm_dat", 64'(m_rdat), {s_rdat, s_rdat});
        if (m_bsy) begin
            chk("wbs_adr_dat", {s_adr, s_wdat}, {m_adr[m_own], m_dat[m_own]});
            chk("wbs_ctl", 64'({s_sel, s_cti, s_bte}),
                64'({m_sel[m_own], m_cti[m_own], m_bte[m_own]}));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        m_adr  = '0;
        m_dat  = '0;
        m_sel  = '0;
        m_we   = '0;
        m_cyc  = '0;
        m_stb  = '0;
        m_cti  = '0;
        m_bte  = '0;
        s_rdat = '0;
        s_ack  = 1'b0;
        s_err  = 1'b0;
        s_rty  = 1'b0;
        tick();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        @(negedge clk);
        chk("rst_cyc", 64'(s_cyc), 64'(1'b0));
        chk("rst_ack", 64'(m_ack), 64'(2'b00));
        tick();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        rst_n = 1'b1;
        tick();

        // Single master on port 1
        m_cyc    = 2'b10;
        m_stb    = 2'b10;
        m_we     = 2'b10;
        m_adr[1] = 32'h1000;
        m_dat[1] = 32'hCAFE0001;
        m_sel[1] = 4'hF;
        m_bte[1] = 2'b01;
        @(negedge clk);
        chk("t1_latency", 64'(s_cyc), 64'(1'b0));
        tick();
        @(negedge clk);
        chk("t1_cyc", 64'(s_cyc), 64'(1'b1));
        chk("t1_adr", 64'(s_adr), 64'(32'h1000));
        chk("t1_noack", 64'(m_ack), 64'(2'b00));
        tick();
        s_ack  = 1'b1;
        s_rdat = 32'h5A5A0001;
        @(negedge clk);
        chk("t1_ack", 64'(m_ack), 64'(2'b10));
        chk("t1_rdat", 64'(m_rdat[0]), 64'(32'h5A5A0001));
        tick();
        s_ack = 1'b0;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        m_we  = 2'b00;
        @(negedge clk);
        chk("t1_release", 64'(s_cyc), 64'(1'b0));
        tick();

        // Contention: m0 is next in line
        m_cyc    = 2'b11;
        m_stb    = 2'b11;
        m_adr[0] = 32'h2000;
        m_adr[1] = 32'h3000;
        m_dat[0] = 32'h0000BEEF;
        m_cti[0] = 3'b010;
        tick();
        @(negedge clk);
        chk("t2_m0_first", 64'(s_adr), 64'(32'h2000));

        // Burst lock: m0 holds the bus for 4 beats while m1 waits
        for (int b = 0; b < 4; b++) begin
            tick();
            m_adr[0] = 32'h2000 + 32'(4 * b);
            m_cti[0] = (b == 3) ? 3'b111 : 3'b010;
            s_ack    = 1'b1;
            @(negedge clk);
            chk("t3_beat_adr", 64'(s_adr), 64'(32'h2000 + 32'(4 * b)));
            chk("t3_beat_ack", 64'(m_ack), 64'(2'b01));
        end
        tick();
        s_ack    = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        m_cti[0] = 3'b000;
        @(negedge clk);
        chk("t3_release_cyc", 64'(s_cyc), 64'(1'b0));
        tick();
        @(negedge clk);
        chk("t3_handoff_cyc", 64'(s_cyc), 64'(1'b1));
        chk("t3_handoff_adr", 64'(s_adr), 64'(32'h3000));
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("t3_m1_ack", 64'(m_ack), 64'(2'b10));

        // Watchdog: m1 stalls, error on the fifth stalled cycle only
        tick();
        s_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_wdt_err", 64'(m_err), (k == 4) ? 64'(2'b10) : 64'(2'b00));
            tick();
        end
        @(negedge clk);
        chk("t4_wdt_restart", 64'(m_err), 64'(2'b00));
        tick();
        tick();
        tick();
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("t5_race_ack", 64'(m_ack), 64'(2'b10));
        chk("t5_race_noerr", 64'(m_err), 64'(2'b00));
        tick();
        s_ack = 1'b0;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();

        // Reset in the middle of m1's transfer
        m_cyc    = 2'b10;
        m_stb    = 2'b10;
        m_adr[1] = 32'h4000;
        tick();
        tick();
        s_ack = 1'b1;
        #2;
        chk("t6_pre_ack", 64'(m_ack), 64'(2'b10));
        rst_n = 1'b0;
        #1;
        chk("t6_async_cyc", 64'(s_cyc), 64'(1'b0));
        chk("t6_async_ack", 64'(m_ack), 64'(2'b00));
        tick();
        s_ack    = 1'b0;
        m_cyc    = 2'b11;
        m_stb    = 2'b11;
        m_adr[0] = 32'h5000;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_m0_after_rst", 64'(s_adr), 64'(32'h5000));
        chk("t6_cyc_after_rst", 64'(s_cyc), 64'(1'b1));

        // Round-robin: handoff to m1, then m0 again, then m1 wins a tie
        tick();
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        tick();
        @(negedge clk);
        chk("t7_handoff", 64'(s_adr), 64'(32'h4000));
        tick();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        @(negedge clk);
        chk("t7_rr_m0", 64'(s_adr), 64'(32'h5000));
        tick();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tick();
        @(negedge clk);
        chk("t7_tie_m1", 64'(s_adr), 64'(32'h4000));
        tick();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/peripheral_msi_arbiter_wb.md
Name: peripheral_msi_arbiter_wb

Overview:
Wishbone N-master to 1-slave arbiter. It is the counterpart of the 1-master to N-slave address-decode mux in the MSI peripheral set: several initiators (CPU data port, DMA, debug) share one slave port. Arbitration is round-robin and the grant is held for the whole cycle. A bus watchdog terminates stalled transfers with an error.

Parameters:
DW, 32, data width
AW, 32, address width
NUM_MASTERS, 2, number of master ports (>=2)
TIMEOUT, 255, slave-stall cycles before the watchdog error; 0 disables the watchdog
MASTER_SEL_BITS, $clog2(NUM_MASTERS), derived width of the grant index

Ports:
wb_clk_i  in  1  clock, all logic on rising edge
wb_rst_ni  in  1  asynchronous active-low reset
wbm_adr_i  in  [NUM_MASTERS-1:0][AW-1:0]  master address
wbm_dat_i  in  [NUM_MASTERS-1:0][DW-1:0]  master write data
wbm_sel_i  in  [NUM_MASTERS-1:0][3:0]  byte selects
wbm_we_i  in  [NUM_MASTERS-1:0]  write enable
wbm_cyc_i  in  [NUM_MASTERS-1:0]  cycle / bus request
wbm_stb_i  in  [NUM_MASTERS-1:0]  strobe
wbm_cti_i  in  [NUM_MASTERS-1:0][2:0]  cycle type
wbm_bte_i  in  [NUM_MASTERS-1:0][1:0]  burst type
wbm_dat_o  out  [NUM_MASTERS-1:0][DW-1:0]  read data, broadcast to all masters
wbm_ack_o  out  [NUM_MASTERS-1:0]  ack, granted master only
wbm_err_o  out  [NUM_MASTERS-1:0]  err, granted master only
wbm_rty_o  out  [NUM_MASTERS-1:0]  retry, granted master only
wbs_adr_o  out  AW  slave address
wbs_dat_o  out  DW  slave write data
wbs_sel_o  out  4  slave byte selects
wbs_we_o  out  1  slave write enable
wbs_cyc_o  out  1  slave cycle
wbs_stb_o  out  1  slave strobe
wbs_cti_o  out  3  slave cycle type
wbs_bte_o  out  2  slave burst type
wbs_dat_i  in  DW  slave read data
wbs_ack_i  in  1  slave ack
wbs_err_i  in  1  slave err
wbs_rty_i  in  1  slave retry

Behaviour:
- State: busy flag, grant index gnt, last-served index last, watchdog counter wdt (width $clog2(TIMEOUT+1), min 1).
- Reset (async, wb_rst_ni low):
  - busy=0, gnt=0, last=NUM_MASTERS-1, so master 0 has first priority; wdt=0.
  - All wbs_cyc_o/stb_o/we_o and wbm_ack_o/err_o/rty_o read 0 while in reset.
- IDLE (busy=0):
  - At an edge where any wbm_cyc_i is high: gnt = first requester searching last+1, last+2, … with wrap modulo NUM_MASTERS; busy=1; last=gnt.
  - Grant latency is one cycle. wbs_cyc_o rises in the cycle after the request is sampled.
- BUSY (busy=1):
  - The grant is held while wbm_cyc_i[gnt]=1; other requests are ignored.
  - At an edge with wbm_cyc_i[gnt]=0:
    - If another master requests, re-arbitrate round-robin from last+1 and stay busy. The handoff has no idle cycle.
    - Otherwise busy=0.
- Slave side:
  - wbs_cyc_o = busy & wbm_cyc_i[gnt]; wbs_stb_o = busy & wbm_stb_i[gnt].
  - adr/dat/sel/we/cti/bte are muxed from gnt (combinational).
  - During a release cycle, wbs_cyc_o follows the still-held gnt, so it is low.
- Master side:
  - wbm_dat_o[i] = wbs_dat_i for all i.
  - ack/rty[i] = busy & (i==gnt) & wbs_ack_i/wbs_rty_i.
  - err[i] = busy & (i==gnt) & (wbs_err_i | wdt_err).
  - Non-granted masters see ack/err/rty = 0.
- Watchdog (TIMEOUT>0):
  - wdt increments each cycle wbs_cyc_o & wbs_stb_o & !(wbs_ack_i|wbs_err_i|wbs_rty_i).
  - wdt clears on any slave termination, when wbs_stb_o=0, or when the grant changes.
  - When wdt==TIMEOUT: wdt_err=1 for exactly that cycle (combinational from the counter), and wdt clears at the next edge.
  - If slave ack and wdt==TIMEOUT coincide, the slave termination wins: ack only, no err.
  - With TIMEOUT=0, wdt_err is constant 0.
- Reset mid-transfer: outputs drop immediately (async). After release, arbitration restarts from master 0 priority.
- Simultaneous requests always resolve by round-robin, never by fixed priority, except immediately after reset.

Test Plan:
- Single master: m1 asserts cyc/stb at edge 1, adr=0x1000 -> wbs_cyc_o=1 from cycle 2 with wbs_adr_o=0x1000; slave acks in cycle 3 -> wbm_ack_o=2'b10.
- Contention after reset: m0 and m1 both request at the same edge -> m0 granted first. When m0 drops cyc, m1 is granted at that edge with no idle cycle. On the next simultaneous request, m0 wins again (round-robin).
- Burst lock: m0 runs a 4-beat burst (cti=3'b010, then 3'b111) while m1 requests throughout -> m1 sees no ack and wbs_adr_o tracks m0 for all 4 beats. m1 is granted after m0 releases.
- Watchdog: TIMEOUT=4, slave never acks -> wbm_err_o[gnt] pulses exactly once, in the cycle where wdt==4. wdt then restarts at 0.
- Watchdog/ack race: slave acks in the same cycle as wdt==TIMEOUT -> ack=1, err=0.
- Reset mid-transfer: assert wb_rst_ni=0 during m1's cycle -> wbs_cyc_o and wbm_ack_o go to 0 asynchronously. After release, simultaneous m0/m1 requests grant m0.
